// File: rtl/bitblade_pkg.sv
// Shared encodings, FSM states and slice-count helper for the BitBlade precision sequencer.
package bitblade_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned SLICE_W = 2;
  localparam int unsigned PREC_W  = 2;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned NS_W    = 3;
  localparam int unsigned PROD_W  = 6;
  localparam int unsigned SHAMT_W = 4;

  localparam logic [PREC_W-1:0] PREC_2B = 2'b00;
  localparam logic [PREC_W-1:0] PREC_4B = 2'b01;
  localparam logic [PREC_W-1:0] PREC_8B = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 2-bit slices for a precision code; the unused code 11 behaves as 8b.
  function automatic logic [NS_W-1:0] n_slices(input logic [PREC_W-1:0] prec);
    case (prec)
      PREC_2B: n_slices = 3'd1;
      PREC_4B: n_slices = 3'd2;
      default: n_slices = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bitblade_precision_seq_mul.sv
// MUL_reconfigurable_3_3: 2b x 2b slice multiplier, each slice optionally the signed MSB slice.
module bitblade_precision_seq_mul
  import bitblade_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               sign_i,
  input  logic               sign_w,
  output logic [PROD_W-1:0]  product_c
);

  logic [PROD_W-1:0] a_ext;
  logic [PROD_W-1:0] b_ext;

  // Extend each slice to 3 bits (signed or zero), then to the product width; mod-64 multiply is exact.
  always_comb begin
    a_ext     = {{(PROD_W-SLICE_W){sign_i & a[SLICE_W-1]}}, a};
    b_ext     = {{(PROD_W-SLICE_W){sign_w & b[SLICE_W-1]}}, b};
    product_c = PROD_W'(a_ext * b_ext);
  end

endmodule

// File: rtl/bitblade_precision_seq.sv
// Sequences one 2b x 2b slice multiplier over 2/4/8-bit operands, shift-accumulating the partial products.
module bitblade_precision_seq
  import bitblade_pkg::*;
#(
  parameter int unsigned ACC_W = 24
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [OP_W-1:0]   IN_A,
  input  logic [OP_W-1:0]   IN_B,
  input  logic [PREC_W-1:0] IN_PREC_I,
  input  logic [PREC_W-1:0] IN_PREC_W,
  input  logic              IN_SIGN_I,
  input  logic              IN_SIGN_W,
  input  logic              IN_ACC,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [ACC_W-1:0]  OUT_RESULT,
  output logic              BUSY
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [NS_W-1:0]   ni_q, ni_d, nw_q, nw_d;
  logic              sign_i_q, sign_i_d, sign_w_q, sign_w_d;
  logic [CNT_W-1:0]  i_q, i_d, j_q, j_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              in_ready_q, out_valid_q, busy_q;

  logic [SLICE_W-1:0] a_slice, b_slice;
  logic               last_i, last_j;
  logic [PROD_W-1:0]  product;
  logic [ACC_W-1:0]   product_ext;
  logic [SHAMT_W-1:0] shamt;

  // Slice muxes, MSB-slice sign flags and shift amount for the current (i, j) pair.
  always_comb begin
    a_slice     = a_q[{i_q, 1'b0} +: SLICE_W];
    b_slice     = b_q[{j_q, 1'b0} +: SLICE_W];
    last_i      = (NS_W'(i_q) == (ni_q - 3'd1));
    last_j      = (NS_W'(j_q) == (nw_q - 3'd1));
    shamt       = SHAMT_W'({i_q, 1'b0}) + SHAMT_W'({j_q, 1'b0});
    product_ext = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  end

  bitblade_precision_seq_mul u_mul (
    .a         (a_slice),
    .b         (b_slice),
    .sign_i    (sign_i_q & last_i),
    .sign_w    (sign_w_q & last_j),
    .product_c (product)
  );

  // Next-state logic: accept in IDLE, one slice pair per RUN cycle, hold result in DONE.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ni_d     = ni_q;
    nw_d     = nw_q;
    sign_i_d = sign_i_q;
    sign_w_d = sign_w_q;
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          a_d      = IN_A;
          b_d      = IN_B;
          ni_d     = n_slices(IN_PREC_I);
          nw_d     = n_slices(IN_PREC_W);
          sign_i_d = IN_SIGN_I;
          sign_w_d = IN_SIGN_W;
          i_d      = '0;
          j_d      = '0;
          if (!IN_ACC) begin
            acc_d = '0;
          end
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + (product_ext << shamt);
        if (last_j) begin
          j_d = '0;
          if (last_i) begin
            state_d = DONE;
          end else begin
            i_d = i_q + 2'd1;
          end
        end else begin
          j_d = j_q + 2'd1;
        end
      end
      DONE: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      ni_q        <= 3'd1;
      nw_q        <= 3'd1;
      sign_i_q    <= 1'b0;
      sign_w_q    <= 1'b0;
      i_q         <= '0;
      j_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ni_q        <= ni_d;
      nw_q        <= nw_d;
      sign_i_q    <= sign_i_d;
      sign_w_q    <= sign_w_d;
      i_q         <= i_d;
      j_q         <= j_d;
      acc_q       <= acc_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign IN_READY   = in_ready_q;
  assign OUT_VALID  = out_valid_q;
  assign OUT_RESULT = acc_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_bitblade_precision_seq.sv
// Randomized and directed checks of the precision sequencer against an arithmetic reference model.
module tb_bitblade_precision_seq;

  localparam int unsigned ACC_W = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [7:0]       in_a, in_b;
  logic [1:0]       in_prec_i, in_prec_w;
  logic             in_sign_i, in_sign_w, in_acc;
  logic             out_valid, out_ready;
  logic [ACC_W-1:0] out_result;
  logic             busy;

  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] model_acc = '0;

  always #5 clk = ~clk;

  bitblade_precision_seq #(.ACC_W(ACC_W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .IN_VALID   (in_valid),
    .IN_READY   (in_ready),
    .IN_A       (in_a),
    .IN_B       (in_b),
    .IN_PREC_I  (in_prec_i),
    .IN_PREC_W  (in_prec_w),
    .IN_SIGN_I  (in_sign_i),
    .IN_SIGN_W  (in_sign_w),
    .IN_ACC     (in_acc),
    .OUT_VALID  (out_valid),
    .OUT_READY  (out_ready),
    .OUT_RESULT (out_result),
    .BUSY       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] prec);
    return (prec == 2'b00) ? 2 : (prec == 2'b01) ? 4 : 8;
  endfunction

  // Numeric value of an operand as the consumer sees it: low w bits, optionally two's complement.
  function automatic int op_value(input logic [7:0] x, input logic [1:0] prec, input logic sgn);
    int w, v;
    w = width_of(prec);
    v = int'(x) & ((1 << w) - 1);
    if (sgn && v >= (1 << (w - 1))) v = v - (1 << w);
    return v;
  endfunction

  // One full transaction: accept, count RUN cycles, check result, optionally stall, then drain.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] pi,
                       input logic [1:0] pw, input logic si, input logic sw, input logic ac,
                       input int hold, output logic [ACC_W-1:0] res);
    int run_cycles, exp_cycles, prod;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_prec_i = pi; in_prec_w = pw;
    in_sign_i = si; in_sign_w = sw; in_acc = ac; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    run_cycles = 0;
    while (!out_valid && run_cycles < 40) begin
      run_cycles++;
      @(posedge clk); #1;
    end
    exp_cycles = (width_of(pi) / 2) * (width_of(pw) / 2);
    check("run_cycles", 32'(run_cycles), 32'(exp_cycles));
    check("out_valid_done", 32'(out_valid), 32'd1);
    prod = op_value(a, pi, si) * op_value(b, pw, sw);
    if (!ac) model_acc = '0;
    model_acc = model_acc + ACC_W'(prod);
    check("result", 32'(out_result), 32'(model_acc));
    res = out_result;
    in_valid = (hold > 0);
    in_a = 8'($urandom); in_b = 8'($urandom); in_acc = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", 32'(out_result), 32'(model_acc));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [ACC_W-1:0] res;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_prec_i = '0; in_prec_w = '0;
    in_sign_i = 1'b0; in_sign_w = 1'b0; in_acc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", 32'(out_result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_op(8'd3, 8'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 0, res);
    check("t1_const", 32'(res), 32'd9);
    do_op(8'h80, 8'h7F, 2'b10, 2'b10, 1'b1, 1'b1, 1'b0, 0, res);
    check("t2_const", 32'(res), 32'hFFC080);
    do_op(8'h0F, 8'd200, 2'b01, 2'b10, 1'b1, 1'b0, 1'b0, 0, res);
    check("t3_const", 32'(res), 32'hFFFF38);
    do_op(8'd5, 8'd6, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 0, res);
    check("t4a_const", 32'(res), 32'd30);
    do_op(8'd2, 8'd7, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1, 0, res);
    check("t4b_const", 32'(res), 32'd44);
    do_op(8'hC3, 8'h5A, 2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 5, res);

    // Reset mid-computation on the 5th RUN cycle of an 8b x 8b op.
    in_a = 8'h9D; in_b = 8'hE7; in_prec_i = 2'b10; in_prec_w = 2'b10;
    in_sign_i = 1'b1; in_sign_w = 1'b1; in_acc = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("t6_busy_before_rst", 32'(busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("t6_in_ready", 32'(in_ready), 32'd1);
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_result", 32'(out_result), 32'd0);
    model_acc = '0;
    do_op(8'd2, 8'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 0, res);
    check("t6_const", 32'(res), 32'd6);

    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)), res);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
